// File: rtl/bus_connect_seq_if.sv
// Control/status bundle between the host or scan logic and the analog bus sequencer.
interface bus_connect_seq_if #(
   parameter int CHANNELS = 8
);
   localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

   logic [SEL_W-1:0]    sel;
   logic                sel_valid;
   logic                sel_ready;
   logic                disconnect;
   logic                scan_en;
   logic                err_clr;
   logic [CHANNELS-1:0] sw_en;
   logic [SEL_W-1:0]    active_ch;
   logic                connected;
   logic                eoc;
   logic                err;

   modport master (
      output sel, sel_valid, disconnect, scan_en, err_clr,
      input  sel_ready, sw_en, active_ch, connected, eoc, err
   );

   modport slave (
      input  sel, sel_valid, disconnect, scan_en, err_clr,
      output sel_ready, sw_en, active_ch, connected, eoc, err
   );
endinterface

// File: rtl/bus_connect_seq.sv
// Break-before-make analog bus switch sequencer with host-select and auto-scan.
module bus_connect_seq_lane (
   input  logic clock,
   input  logic reset,
   input  logic en_d,
   output logic en_q
);
   always_ff @(posedge clock or negedge reset)
      if (!reset) en_q <= 1'b0;
      else        en_q <= en_d;
endmodule

module bus_connect_seq #(
   parameter int CHANNELS      = 8,
   parameter int DEAD_CYCLES   = 2,
   parameter int SETTLE_CYCLES = 4,
   parameter int DWELL_CYCLES  = 16
) (
   input logic                 clock,
   input logic                 reset,
   bus_connect_seq_if.slave    bus
);
   localparam int SEL_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
   localparam int MAXC_A = (DEAD_CYCLES > SETTLE_CYCLES) ? DEAD_CYCLES : SETTLE_CYCLES;
   localparam int MAXC   = (MAXC_A > DWELL_CYCLES) ? MAXC_A : DWELL_CYCLES;
   localparam int CW     = $clog2(MAXC + 1);
   localparam logic [CW-1:0] DEAD_LAST   = CW'(DEAD_CYCLES - 1);
   localparam logic [CW-1:0] SETTLE_LAST = CW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] DWELL_LAST  = CW'(DWELL_CYCLES - 1);
   localparam logic [SEL_W-1:0] LAST_CH  = SEL_W'(CHANNELS - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_BREAK, ST_MAKE, ST_CONN} st_t;

   st_t                 st, st_n;
   logic [SEL_W-1:0]    act, act_n, act_inc;
   logic [CW-1:0]       cnt, cnt_n;
   logic                err_q, err_n, eoc_q, eoc_n, conn_q;
   logic                accept, bad_sel;
   logic [CHANNELS-1:0] sw_d, sw_q;

   assign bus.sel_ready = !bus.scan_en && (st == ST_IDLE || st == ST_CONN);
   assign accept        = bus.sel_valid && bus.sel_ready && !bus.disconnect;
   assign bad_sel       = {1'b0, bus.sel} >= (SEL_W+1)'(CHANNELS);
   assign act_inc       = (act == LAST_CH) ? '0 : act + SEL_W'(1);

   always_comb begin
      st_n  = st;
      act_n = act;
      cnt_n = cnt;
      err_n = err_q;
      eoc_n = 1'b0;
      if (bus.err_clr) err_n = 1'b0;
      if (bus.disconnect) begin
         st_n = ST_IDLE;
      end else begin
         case (st)
            ST_IDLE:
               if (bus.scan_en) begin
                  act_n = '0;
                  st_n  = ST_MAKE;
               end else if (accept) begin
                  if (bad_sel) err_n = 1'b1;
                  else begin
                     act_n = bus.sel;
                     st_n  = ST_MAKE;
                  end
               end
            ST_BREAK:
               if (cnt == DEAD_LAST) st_n = ST_MAKE;
               else                  cnt_n = cnt + CW'(1);
            ST_MAKE:
               if (cnt == SETTLE_LAST) st_n = ST_CONN;
               else                    cnt_n = cnt + CW'(1);
            ST_CONN:
               if (bus.scan_en) begin
                  if (cnt == DWELL_LAST) begin
                     act_n = act_inc;
                     st_n  = ST_BREAK;
                     eoc_n = (act == LAST_CH);
                  end else cnt_n = cnt + CW'(1);
               end else begin
                  // dwell only runs while scanning, so a later scan_en starts fresh
                  cnt_n = '0;
                  if (accept) begin
                     if (bad_sel) err_n = 1'b1;
                     else if (bus.sel != act) begin
                        act_n = bus.sel;
                        st_n  = ST_BREAK;
                     end
                  end
               end
            default: st_n = ST_IDLE;
         endcase
      end
      if (st_n != st) cnt_n = '0;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         st     <= ST_IDLE;
         act    <= '0;
         cnt    <= '0;
         err_q  <= 1'b0;
         eoc_q  <= 1'b0;
         conn_q <= 1'b0;
      end else begin
         st     <= st_n;
         act    <= act_n;
         cnt    <= cnt_n;
         err_q  <= err_n;
         eoc_q  <= eoc_n;
         conn_q <= (st_n == ST_CONN);
      end
   end

   // switch enables are registered from next state, so BREAK/IDLE open them on the same edge
   for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
      assign sw_d[i] = (st_n == ST_MAKE || st_n == ST_CONN) && (act_n == SEL_W'(i));
      bus_connect_seq_lane u_lane (
         .clock (clock),
         .reset (reset),
         .en_d  (sw_d[i]),
         .en_q  (sw_q[i])
      );
   end

   assign bus.sw_en     = sw_q;
   assign bus.active_ch = act;
   assign bus.connected = conn_q;
   assign bus.eoc       = eoc_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_bus_connect_seq.sv
// Directed bench: main 8-channel instance plus a 6-channel instance for range errors.
module tb_bus_connect_seq;
   logic clock = 1'b0;
   logic reset = 1'b0;
   int   total = 0;
   int   bad   = 0;

   always #5 clock = ~clock;

   bus_connect_seq_if #(.CHANNELS(8)) bus ();
   bus_connect_seq_if #(.CHANNELS(6)) ebus ();

   bus_connect_seq #(.CHANNELS(8), .DEAD_CYCLES(2), .SETTLE_CYCLES(4), .DWELL_CYCLES(3)) u_dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // sel=9 cannot be expressed on a 3-bit select, so range checks use 6 channels
   bus_connect_seq #(.CHANNELS(6)) u_err (
      .clock (clock),
      .reset (reset),
      .bus   (ebus)
   );

   always @(negedge clock) begin
      total++;
      if ($countones(bus.sw_en) > 1) begin
         bad++;
         $display("FAIL onehot sw_en=%h", bus.sw_en);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      bus.sel = '0; bus.sel_valid = 0; bus.disconnect = 0; bus.scan_en = 0; bus.err_clr = 0;
      ebus.sel = '0; ebus.sel_valid = 0; ebus.disconnect = 0; ebus.scan_en = 0; ebus.err_clr = 0;
      #12;
      total++; if (bus.sw_en !== 8'h00) begin bad++; $display("FAIL rst_sw got=%h exp=00", bus.sw_en); end
      total++; if (bus.active_ch !== 3'd0) begin bad++; $display("FAIL rst_act got=%0d exp=0", bus.active_ch); end
      total++; if ({bus.connected, bus.eoc, bus.err} !== 3'b000) begin bad++; $display("FAIL rst_flags got=%b exp=000", {bus.connected, bus.eoc, bus.err}); end
      reset = 1'b1;
      tick(2);
      total++; if (bus.sel_ready !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", bus.sel_ready); end
   endtask

   task automatic test_select_idle;
      bus.sel = 3'd3; bus.sel_valid = 1;
      tick(1);
      bus.sel_valid = 0;
      total++; if (bus.sw_en !== 8'h08) begin bad++; $display("FAIL idle_make got=%h exp=08", bus.sw_en); end
      total++; if (bus.active_ch !== 3'd3) begin bad++; $display("FAIL idle_act got=%0d exp=3", bus.active_ch); end
      tick(3);
      total++; if (bus.connected !== 1'b0) begin bad++; $display("FAIL idle_settle got=%b exp=0", bus.connected); end
      tick(1);
      total++; if (bus.connected !== 1'b1) begin bad++; $display("FAIL idle_conn got=%b exp=1", bus.connected); end
      total++; if (bus.sel_ready !== 1'b1) begin bad++; $display("FAIL idle_ready got=%b exp=1", bus.sel_ready); end
   endtask

   task automatic test_switch;
      bus.sel = 3'd5; bus.sel_valid = 1;
      tick(1);
      bus.sel_valid = 0;
      total++; if ({bus.sw_en, bus.connected} !== 9'h000) begin bad++; $display("FAIL sw_brk1 got=%h/%b exp=00/0", bus.sw_en, bus.connected); end
      tick(1);
      total++; if (bus.sw_en !== 8'h00) begin bad++; $display("FAIL sw_brk2 got=%h exp=00", bus.sw_en); end
      tick(1);
      total++; if (bus.sw_en !== 8'h20) begin bad++; $display("FAIL sw_make got=%h exp=20", bus.sw_en); end
      tick(3);
      total++; if (bus.connected !== 1'b0) begin bad++; $display("FAIL sw_settle got=%b exp=0", bus.connected); end
      tick(1);
      total++; if (bus.connected !== 1'b1) begin bad++; $display("FAIL sw_conn got=%b exp=1", bus.connected); end
   endtask

   task automatic test_same_noop;
      bus.sel = 3'd5; bus.sel_valid = 1;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         total++; if ({bus.sw_en, bus.connected} !== {8'h20, 1'b1}) begin bad++; $display("FAIL noop cyc=%0d got=%h/%b exp=20/1", i, bus.sw_en, bus.connected); end
      end
      bus.sel_valid = 0;
   endtask

   task automatic test_err;
      ebus.sel = 3'd7; ebus.sel_valid = 1;
      tick(1);
      total++; if ({ebus.err, ebus.sw_en, ebus.active_ch} !== {1'b1, 6'h00, 3'd0}) begin bad++; $display("FAIL err_idle got=%b/%h/%0d exp=1/00/0", ebus.err, ebus.sw_en, ebus.active_ch); end
      ebus.sel = 3'd6; ebus.err_clr = 1;
      tick(1);
      ebus.sel_valid = 0;
      total++; if (ebus.err !== 1'b1) begin bad++; $display("FAIL err_setwins got=%b exp=1", ebus.err); end
      tick(1);
      ebus.err_clr = 0;
      total++; if (ebus.err !== 1'b0) begin bad++; $display("FAIL err_clr got=%b exp=0", ebus.err); end
      ebus.sel = 3'd2; ebus.sel_valid = 1;
      tick(1);
      ebus.sel_valid = 0;
      tick(4);
      ebus.sel = 3'd7; ebus.sel_valid = 1;
      tick(1);
      ebus.sel_valid = 0;
      total++; if ({ebus.err, ebus.sw_en, ebus.connected, ebus.active_ch} !== {1'b1, 6'h04, 1'b1, 3'd2}) begin bad++; $display("FAIL err_conn got=%b/%h/%b/%0d exp=1/04/1/2", ebus.err, ebus.sw_en, ebus.connected, ebus.active_ch); end
      tick(1);
      total++; if (ebus.sw_en !== 6'h04) begin bad++; $display("FAIL err_hold got=%h exp=04", ebus.sw_en); end
   endtask

   task automatic test_disconnect;
      bus.sel = 3'd1; bus.sel_valid = 1;
      tick(1);
      bus.sel_valid = 0;
      tick(2);
      total++; if (bus.sw_en !== 8'h02) begin bad++; $display("FAIL dis_premake got=%h exp=02", bus.sw_en); end
      bus.disconnect = 1; bus.sel = 3'd4; bus.sel_valid = 1;
      tick(1);
      bus.disconnect = 0; bus.sel_valid = 0;
      total++; if ({bus.sw_en, bus.connected} !== 9'h000) begin bad++; $display("FAIL dis_make got=%h/%b exp=00/0", bus.sw_en, bus.connected); end
      tick(2);
      total++; if (bus.sw_en !== 8'h00) begin bad++; $display("FAIL dis_idle got=%h exp=00", bus.sw_en); end
      bus.sel = 3'd2; bus.sel_valid = 1;
      tick(1);
      bus.sel_valid = 0;
      tick(4);
      total++; if ({bus.sw_en, bus.connected} !== {8'h04, 1'b1}) begin bad++; $display("FAIL dis_reconn got=%h/%b exp=04/1", bus.sw_en, bus.connected); end
      bus.disconnect = 1; bus.sel = 3'd6; bus.sel_valid = 1;
      tick(1);
      bus.disconnect = 0; bus.sel_valid = 0;
      total++; if ({bus.sw_en, bus.connected} !== 9'h000) begin bad++; $display("FAIL dis_conn got=%h/%b exp=00/0", bus.sw_en, bus.connected); end
      tick(2);
      total++; if (bus.sw_en !== 8'h00) begin bad++; $display("FAIL dis_noaccept got=%h exp=00", bus.sw_en); end
   endtask

   task automatic test_scan;
      int          eoc_seen;
      logic [7:0]  exp_sw;
      logic        exp_conn, exp_eoc;
      eoc_seen = 0;
      bus.scan_en = 1;
      // per channel: 4 MAKE + 3 CONN + 2 BREAK = 9 edges
      for (int n = 1; n <= 73; n++) begin
         int c, r;
         tick(1);
         c = (n - 1) / 9;
         r = (n - 1) % 9;
         exp_sw   = (r <= 6) ? (8'h01 << (c % 8)) : 8'h00;
         exp_conn = (r >= 4 && r <= 6);
         exp_eoc  = (r == 7 && c == 7);
         if (bus.eoc) eoc_seen++;
         total++;
         if ({bus.sw_en, bus.connected, bus.eoc} !== {exp_sw, exp_conn, exp_eoc}) begin
            bad++;
            $display("FAIL scan n=%0d got=%h/%b/%b exp=%h/%b/%b", n, bus.sw_en, bus.connected, bus.eoc, exp_sw, exp_conn, exp_eoc);
         end
      end
      total++; if (eoc_seen != 1) begin bad++; $display("FAIL scan_eoc_count got=%0d exp=1", eoc_seen); end
      bus.scan_en = 0;
      #1;
      total++; if (bus.sel_ready !== 1'b0) begin bad++; $display("FAIL drop_ready_make got=%b exp=0", bus.sel_ready); end
      tick(3);
      total++; if (bus.connected !== 1'b0) begin bad++; $display("FAIL drop_settle got=%b exp=0", bus.connected); end
      tick(1);
      total++; if ({bus.connected, bus.sel_ready, bus.active_ch} !== {1'b1, 1'b1, 3'd0}) begin bad++; $display("FAIL drop_conn got=%b/%b/%0d exp=1/1/0", bus.connected, bus.sel_ready, bus.active_ch); end
      tick(5);
      total++; if ({bus.sw_en, bus.connected} !== {8'h01, 1'b1}) begin bad++; $display("FAIL drop_hold got=%h/%b exp=01/1", bus.sw_en, bus.connected); end
   endtask

   task automatic test_reset_async;
      bus.sel = 3'd6; bus.sel_valid = 1;
      tick(1);
      bus.sel_valid = 0;
      #3 reset = 1'b0;
      #1;
      total++; if ({bus.sw_en, bus.connected, bus.active_ch, bus.eoc, bus.err} !== 14'h0) begin bad++; $display("FAIL arst_break got=%h/%b/%0d/%b/%b exp=0", bus.sw_en, bus.connected, bus.active_ch, bus.eoc, bus.err); end
      #2 reset = 1'b1;
      tick(1);
      bus.sel = 3'd3; bus.sel_valid = 1;
      tick(1);
      bus.sel_valid = 0;
      tick(4);
      total++; if ({bus.sw_en, bus.connected} !== {8'h08, 1'b1}) begin bad++; $display("FAIL arst_preconn got=%h/%b exp=08/1", bus.sw_en, bus.connected); end
      #3 reset = 1'b0;
      #1;
      total++; if ({bus.sw_en, bus.connected, bus.active_ch} !== 12'h0) begin bad++; $display("FAIL arst_conn got=%h/%b/%0d exp=00/0/0", bus.sw_en, bus.connected, bus.active_ch); end
      #2 reset = 1'b1;
      tick(2);
      total++; if ({bus.sw_en, bus.sel_ready} !== {8'h00, 1'b1}) begin bad++; $display("FAIL arst_after got=%h/%b exp=00/1", bus.sw_en, bus.sel_ready); end
   endtask

   initial begin
      test_reset;
      test_select_idle;
      test_switch;
      test_same_noop;
      test_err;
      test_disconnect;
      test_scan;
      test_reset_async;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
